// File: rtl/speed_pi_controller_if.sv
//------------------------------------------------------------------------------
// speed_pi_controller_if : encoder sample in, PWM duty command out
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface speed_pi_controller_if;
   logic [31:0] period;
   logic        period_valid;
   logic [31:0] desired_period;
   logic [9:0]  duty_cycle;
   logic        duty_valid;
   logic        busy;
   logic        overrun;

   modport master (
      output period, period_valid, desired_period,
      input  duty_cycle, duty_valid, busy, overrun
   );

   modport slave (
      input  period, period_valid, desired_period,
      output duty_cycle, duty_valid, busy, overrun
   );
endinterface

`default_nettype wire

// File: rtl/speed_pi_controller.sv
//------------------------------------------------------------------------------
// speed_pi_controller : multi-cycle PI loop turning encoder period error into
// a 10-bit PWM duty command. Define SPEED_PI_ANTIWINDUP_EN for anti-windup.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module speed_pi_controller #(
   parameter logic [15:0]        KP        = 16'd256,
   parameter logic [15:0]        KI        = 16'd16,
   parameter logic signed [31:0] INT_LIMIT = 32'sd1048576
) (
   input  logic                  clk,
   input  logic                  reset,
   speed_pi_controller_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ERR   = 3'd1,
      S_PTERM = 3'd2,
      S_ITERM = 3'd3,
      S_SUM   = 3'd4
   } state_t;

   localparam logic signed [32:0] c_ERR_HI  = 33'sd8388607;
   localparam logic signed [32:0] c_ERR_LO  = -33'sd8388608;
   localparam logic signed [32:0] c_INT_HI  = {INT_LIMIT[31], INT_LIMIT};
   localparam logic signed [32:0] c_INT_LO  = -c_INT_HI;
   localparam logic signed [48:0] c_DUTY_HI = 49'sd1023;

   state_t              r_state;
   logic [31:0]         r_period;
   logic signed [23:0]  r_err;
   logic signed [39:0]  r_p;
   logic signed [31:0]  r_int_next;
   logic signed [47:0]  r_i;
   logic signed [31:0]  r_integ;
   logic [9:0]          r_duty;
   logic                r_duty_valid;
   logic                r_busy;
   logic                r_overrun;

   logic signed [32:0]  w_err_raw;
   logic signed [23:0]  w_err_sat;
   logic signed [40:0]  w_p_prod;
   logic signed [39:0]  w_p_shift;
   logic signed [32:0]  w_int_sum;
   logic signed [31:0]  w_int_sat;
   logic signed [48:0]  w_i_prod;
   logic signed [47:0]  w_i_shift;
   logic signed [48:0]  w_u;
   logic                w_u_lo;
   logic                w_u_hi;
   logic [9:0]          w_duty;
   logic                w_commit;

   // Error is formed in 33 bits so an unsigned 32-bit difference cannot wrap
   assign w_err_raw = $signed({1'b0, r_period}) - $signed({1'b0, bus.desired_period});
   assign w_err_sat = (w_err_raw > c_ERR_HI) ? 24'sh7FFFFF :
                      (w_err_raw < c_ERR_LO) ? 24'sh800000 :
                      w_err_raw[23:0];

   assign w_p_prod  = $signed({{17{r_err[23]}}, r_err}) * $signed({25'd0, KP});
   assign w_p_shift = 40'(w_p_prod >>> 8);

   assign w_int_sum = $signed({r_integ[31], r_integ}) + $signed({{9{r_err[23]}}, r_err});
   assign w_int_sat = (w_int_sum > c_INT_HI) ? c_INT_HI[31:0] :
                      (w_int_sum < c_INT_LO) ? c_INT_LO[31:0] :
                      w_int_sum[31:0];

   assign w_i_prod  = $signed({{17{r_int_next[31]}}, r_int_next}) * $signed({33'd0, KI});
   assign w_i_shift = 48'(w_i_prod >>> 8);

   assign w_u    = $signed({{9{r_p[39]}}, r_p}) + $signed({r_i[47], r_i});
   assign w_u_lo = w_u[48];
   assign w_u_hi = !w_u[48] && (w_u > c_DUTY_HI);
   assign w_duty = w_u_lo ? 10'd0 : (w_u_hi ? 10'd1023 : w_u[9:0]);

`ifdef SPEED_PI_ANTIWINDUP_EN
   logic w_err_pos;
   logic w_err_neg;
   assign w_err_pos = !r_err[23] && (r_err != 24'sd0);
   assign w_err_neg = r_err[23];
   // Freeze the integrator while the output is saturated in the error's direction
   assign w_commit  = !((w_u_hi && w_err_pos) || (w_u_lo && w_err_neg));
`else
   assign w_commit  = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_period     <= 32'd0;
         r_err        <= 24'sd0;
         r_p          <= 40'sd0;
         r_int_next   <= 32'sd0;
         r_i          <= 48'sd0;
         r_integ      <= 32'sd0;
         r_duty       <= 10'd0;
         r_duty_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_duty_valid <= 1'b0;
         r_overrun    <= (r_state != S_IDLE) && bus.period_valid;
         case (r_state)
            S_IDLE: begin
               if (bus.period_valid) begin
                  r_period <= bus.period;
                  r_busy   <= 1'b1;
                  r_state  <= S_ERR;
               end
            end
            S_ERR: begin
               r_err   <= w_err_sat;
               r_state <= S_PTERM;
            end
            S_PTERM: begin
               r_p        <= w_p_shift;
               r_int_next <= w_int_sat;
               r_state    <= S_ITERM;
            end
            S_ITERM: begin
               r_i     <= w_i_shift;
               r_state <= S_SUM;
            end
            S_SUM: begin
               r_duty       <= w_duty;
               r_duty_valid <= 1'b1;
               r_busy       <= 1'b0;
               if (w_commit) begin
                  r_integ <= r_int_next;
               end
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.duty_cycle = r_duty;
   assign bus.duty_valid = r_duty_valid;
   assign bus.busy       = r_busy;
   assign bus.overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_speed_pi_controller.sv
//------------------------------------------------------------------------------
// tb_speed_pi_controller : directed self-checking bench for speed_pi_controller
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_speed_pi_controller;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   int   dv_count;
   int   ovr_count;
   int   dv0;
   int   ovr0;
   int   lat;

`ifdef SPEED_PI_ANTIWINDUP_EN
   localparam int c_INT_21000 = 0;
   localparam int c_INT_STALL = 0;
   localparam int c_INT_19000 = 0;
`else
   localparam int c_INT_21000 = 1000;
   localparam int c_INT_STALL = 1048576;
   localparam int c_INT_19000 = -1000;
`endif

   speed_pi_controller_if bus ();

   speed_pi_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.duty_valid) dv_count <= dv_count + 1;
      if (bus.overrun)    ovr_count <= ovr_count + 1;
   end

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Returns number of edges from the current (valid) cycle to duty_valid
   task automatic wait_dv(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         bus.period_valid = 1'b0;
         n++;
      end while (!bus.duty_valid && n < 20);
   endtask

   task automatic send(input logic [31:0] p, output int n);
      bus.period       = p;
      bus.period_valid = 1'b1;
      wait_dv(n);
   endtask

   task automatic apply_reset();
      bus.period_valid = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      n_tests = 0; n_fail = 0; dv_count = 0; ovr_count = 0;
      reset = 1'b1;
      bus.period = 32'd0;
      bus.period_valid = 1'b0;
      bus.desired_period = 32'd20000;
      repeat (3) @(posedge clk); #1;
      check("rst_duty", bus.duty_cycle, 0);
      check("rst_dv", bus.duty_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_ovr", bus.overrun, 0);
      check("rst_integ", dut.r_integ, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Nominal sample, latency and hold
      dv0 = dv_count;
      bus.period = 32'd20100;
      bus.period_valid = 1'b1;
      @(posedge clk); #1;
      bus.period_valid = 1'b0;
      check("busy_set", bus.busy, 1);
      wait_dv(lat);
      check("nom_latency", lat + 1, 5);
      check("nom_duty", bus.duty_cycle, 106);
      check("nom_integ", dut.r_integ, 100);
      repeat (3) @(posedge clk); #1;
      check("nom_hold", bus.duty_cycle, 106);
      check("nom_dv_cnt", dv_count - dv0, 1);
      check("nom_idle", bus.busy, 0);

      // Upper clamp with moderate error
      apply_reset();
      send(32'd21000, lat);
      check("hi_duty", bus.duty_cycle, 1023);
      check("hi_integ", dut.r_integ, c_INT_21000);

      // Stalled encoder
      apply_reset();
      send(32'h7FFF_FFFF, lat);
      check("stall_duty", bus.duty_cycle, 1023);
      check("stall_integ", dut.r_integ, c_INT_STALL);

      // Negative error floors at zero
      apply_reset();
      send(32'd19000, lat);
      check("neg_duty", bus.duty_cycle, 0);
      check("neg_integ", dut.r_integ, c_INT_19000);

      // Overrun during computation
      apply_reset();
      dv0 = dv_count; ovr0 = ovr_count;
      bus.period = 32'd20100;
      bus.period_valid = 1'b1;
      @(posedge clk); #1;
      bus.period_valid = 1'b0;
      @(posedge clk); #1;
      bus.period = 32'd30000;
      bus.period_valid = 1'b1;
      @(posedge clk); #1;
      bus.period_valid = 1'b0;
      check("ovr_pulse", bus.overrun, 1);
      wait_dv(lat);
      check("ovr_latency", lat + 3, 5);
      repeat (3) @(posedge clk); #1;
      check("ovr_cnt", ovr_count - ovr0, 1);
      check("ovr_dv_cnt", dv_count - dv0, 1);
      check("ovr_duty", bus.duty_cycle, 106);
      check("ovr_integ", dut.r_integ, 100);

      // Async reset while in PTERM aborts the computation
      bus.period = 32'd20100;
      bus.period_valid = 1'b1;
      @(posedge clk); #1;
      bus.period_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("abort_duty_async", bus.duty_cycle, 0);
      check("abort_busy_async", bus.busy, 0);
      repeat (2) @(posedge clk); #1;
      reset = 1'b0;
      dv0 = dv_count;
      repeat (8) @(posedge clk); #1;
      check("abort_no_dv", dv_count - dv0, 0);
      check("abort_duty", bus.duty_cycle, 0);
      check("abort_integ", dut.r_integ, 0);
      send(32'd20100, lat);
      check("abort_next_duty", bus.duty_cycle, 106);
      check("abort_next_integ", dut.r_integ, 100);

      // Back-to-back samples accepted on each duty_valid cycle
      apply_reset();
      dv0 = dv_count; ovr0 = ovr_count;
      bus.period = 32'd20100;
      bus.period_valid = 1'b1;
      for (int s = 0; s < 4; s++) begin
         logic [9:0] exp_duty [4];
         exp_duty = '{10'd106, 10'd112, 10'd118, 10'd125};
         wait_dv(lat);
         check($sformatf("b2b_latency%0d", s), lat, 5);
         check($sformatf("b2b_duty%0d", s), bus.duty_cycle, exp_duty[s]);
         if (s < 3) bus.period_valid = 1'b1;
      end
      repeat (3) @(posedge clk); #1;
      check("b2b_dv_cnt", dv_count - dv0, 4);
      check("b2b_ovr_cnt", ovr_count - ovr0, 0);
      check("b2b_integ", dut.r_integ, 400);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/speed_pi_controller.md
SPEED_PI_CONTROLLER -- requirements
Module: speed_pi_controller

Interface
REQ-001 The block SHALL take parameter KP, default 16'd256: unsigned proportional gain, Q8.8.
REQ-002 The block SHALL take parameter KI, default 16'd16: unsigned integral gain, Q8.8.
REQ-003 The block SHALL take parameter INT_LIMIT, default 32'sd1048576: integrator magnitude bound.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state on posedge clk.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-006 The block SHALL have port period, input, 32 bits: latest encoder period in clk cycles, unsigned.
REQ-007 The block SHALL have port period_valid, input, 1 bit: one-cycle strobe, period is new.
REQ-008 The block SHALL have port desired_period, input, 32 bits: setpoint period, unsigned.
REQ-009 The block SHALL have port duty_cycle, output, 10 bits: registered duty command to the PWM stage.
REQ-010 The block SHALL have port duty_valid, output, 1 bit: one-cycle pulse when duty_cycle updates.
REQ-011 The block SHALL have port busy, output, 1 bit: high while any state other than IDLE is active.
REQ-012 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a sample is dropped.

Function
REQ-013 The FSM SHALL cycle through IDLE -> ERR -> PTERM -> ITERM -> SUM -> IDLE, one clk per state.
REQ-014 IDLE SHALL capture period when period_valid=1 and go to ERR; otherwise it SHALL stay in IDLE.
REQ-015 ERR SHALL compute err = period - desired_period (33-bit signed) and clamp it to signed 24-bit [-8388608, 8388607].
REQ-016 PTERM SHALL compute p = (err*KP) >>> 8 (40-bit signed, arithmetic shift) and int_next = integ + err, clamped to [-INT_LIMIT, INT_LIMIT].
REQ-017 ITERM SHALL compute i = (int_next*KI) >>> 8 (48-bit signed).
REQ-018 SUM SHALL compute u = p + i, clamp it to [0, 1023], register the result to duty_cycle, and commit int_next to integ, subject to REQ-026/027.
REQ-019 duty_valid SHALL pulse high for exactly one cycle, on the cycle after SUM; latency from the period_valid cycle to duty_valid is 5 clk.
REQ-020 duty_cycle SHALL hold its value between updates.
REQ-021 A period_valid while busy=1 SHALL be discarded and SHALL pulse overrun for one cycle; the in-flight computation SHALL be unaffected.
REQ-022 A period_valid in the same cycle the FSM returns to IDLE (the duty_valid cycle) SHALL be accepted.
REQ-023 Positive err (motor slow) SHALL increase duty; period=32'h7FFF_FFFF (stalled/reset encoder) SHALL drive duty to 1023 via the clamp.

Reset
REQ-024 While reset=1, the block SHALL hold duty_cycle=0, duty_valid=0, busy=0, overrun=0, integ=0 and state=IDLE, asynchronously.
REQ-025 Reset mid-computation SHALL abort it with no duty_valid pulse; after reset release, the next period_valid SHALL start a fresh computation.

Configuration
REQ-026 With SPEED_PI_ANTIWINDUP_EN defined, SUM SHALL NOT commit int_next when (u>1023 and err>0) or (u<0 and err<0); integ SHALL keep its old value.
REQ-027 Without SPEED_PI_ANTIWINDUP_EN, SUM SHALL always commit int_next, bounded only by INT_LIMIT.

Verification
REQ-028 Default parameters, desired_period=20000, one period_valid with period=20100 from reset -> duty_valid 5 cycles later, duty_cycle=106 (p=100, i=6), integ=100.
REQ-029 period=32'h7FFF_FFFF, desired_period=20000 -> duty_cycle=1023; integ=8388607 clamped to 1048576 (macro off) or unchanged at 0 (macro on).
REQ-030 From reset, period=19000, desired_period=20000 -> duty_cycle=0; integ=-1000 with macro off, 0 with macro on.
REQ-031 period_valid (period=20100) then a second period_valid 2 cycles later -> one overrun pulse on the second, exactly one duty_valid, duty_cycle=106.
REQ-032 Assert reset while in PTERM, then release -> duty_cycle=0 and no duty_valid; next period_valid=20100 -> duty_cycle=106.
REQ-033 Back-to-back period_valid (period=20100) on each duty_valid cycle, 4 samples -> 4 duty_valid pulses, no overrun, integ=400, final duty_cycle=125.
